// File: rtl/apb2axi_drain_scheduler.sv
// apb2axi_drain_scheduler
// Drains per-tag APB read completions one word at a time. A ready tag is picked
// round-robin, each host word request becomes one data_req to the response
// handler, every word has a timeout, and the tag is handed back to the
// allocator once its last word (or an error/timeout word) has been forwarded.
module apb2axi_drain_scheduler #(
    parameter int TAG_W   = 3,
    parameter int APB_W   = 32,
    parameter int WORDS_W = 12,
    parameter int TIMEOUT = 256
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               cpl_vld,
    input  logic [TAG_W-1:0]   cpl_tag,
    input  logic [WORDS_W-1:0] cpl_words,
    input  logic               cpl_err,
    output logic               cpl_ready,
    input  logic               host_req,
    output logic               host_vld,
    output logic [APB_W-1:0]   host_data,
    output logic [TAG_W-1:0]   host_tag,
    output logic               host_last,
    output logic               host_err,
    output logic               data_req,
    output logic [TAG_W-1:0]   data_req_tag,
    output logic               data_ready,
    input  logic               data_valid,
    input  logic [APB_W-1:0]   data_out,
    input  logic               data_last,
    output logic               tag_free_vld,
    output logic [TAG_W-1:0]   tag_free_tag
);

    localparam int N_TAG = 2 ** TAG_W;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        ISSUE,
        WAIT,
        RELEASE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TAG_W-1:0]     cur_tag;
    logic [TAG_W-1:0]     rr_ptr;
    logic [TMR_W-1:0]     tmr;
    logic [N_TAG-1:0]     pending;
    logic [WORDS_W-1:0]   remain [N_TAG];
    logic [N_TAG-1:0]     err_tag;

    logic                 grant_vld;
    logic [TAG_W-1:0]     grant_tag;
    logic [TAG_W-1:0]     idx;
    logic [WORDS_W-1:0]   cur_remain;
    logic                 word_last;
    logic                 tmr_exp;

    assign cur_remain = remain[cur_tag];
    assign word_last  = (cur_remain == WORDS_W'(1)) || data_last;
    assign tmr_exp    = (tmr == TMR_W'(TIMEOUT - 1));

    // Round-robin search over pending tags, starting at rr_ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_tag = '0;
        idx       = '0;
        for (int i = 0; i < N_TAG; i++) begin
            idx = rr_ptr + TAG_W'(i);
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_tag = idx;
            end
        end
    end

    // Next-state decode plus the handshake/strobe outputs that follow the state
    always_comb begin
        state_nxt    = state;
        cpl_ready    = presetn && !pending[cpl_tag];
        data_req     = 1'b0;
        data_req_tag = '0;
        data_ready   = 1'b0;
        tag_free_vld = 1'b0;
        tag_free_tag = '0;
        case (state)
            IDLE: begin
                if (grant_vld) state_nxt = SEL;
            end
            SEL: begin
                if (host_req) state_nxt = (cur_remain == '0) ? RELEASE : ISSUE;
            end
            ISSUE: begin
                data_req     = 1'b1;
                data_req_tag = cur_tag;
                state_nxt    = WAIT;
            end
            WAIT: begin
                data_ready = 1'b1;
                if (data_valid)   state_nxt = word_last ? RELEASE : SEL;
                else if (tmr_exp) state_nxt = RELEASE;
            end
            RELEASE: begin
                tag_free_vld = 1'b1;
                tag_free_tag = cur_tag;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, current tag, round-robin pointer and word timer
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            cur_tag <= '0;
            rr_ptr  <= '0;
            tmr     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                cur_tag <= grant_tag;
                rr_ptr  <= grant_tag + TAG_W'(1);
            end
            if (state == ISSUE) tmr <= '0;
            else if (state == WAIT && !data_valid && !tmr_exp) tmr <= tmr + TMR_W'(1);
        end
    end

    // Host word register: one-cycle pulse for data words, empty-tag and timeout words
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            host_vld  <= 1'b0;
            host_data <= '0;
            host_tag  <= '0;
            host_last <= 1'b0;
            host_err  <= 1'b0;
        end else begin
            host_vld  <= 1'b0;
            host_data <= '0;
            host_tag  <= '0;
            host_last <= 1'b0;
            host_err  <= 1'b0;
            if (state == SEL && host_req && cur_remain == '0) begin
                host_vld  <= 1'b1;
                host_tag  <= cur_tag;
                host_last <= 1'b1;
                host_err  <= err_tag[cur_tag];
            end else if (state == WAIT && data_valid) begin
                host_vld  <= 1'b1;
                host_data <= data_out;
                host_tag  <= cur_tag;
                host_last <= word_last;
                host_err  <= err_tag[cur_tag];
            end else if (state == WAIT && tmr_exp) begin
                host_vld  <= 1'b1;
                host_tag  <= cur_tag;
                host_last <= 1'b1;
                host_err  <= 1'b1;
            end
        end
    end

    // Per-tag completion table: accept, count down words, clear on release
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pending <= '0;
            err_tag <= '0;
            for (int i = 0; i < N_TAG; i++) remain[i] <= '0;
        end else begin
            if (state == RELEASE) begin
                pending[cur_tag] <= 1'b0;
                remain[cur_tag]  <= '0;
                err_tag[cur_tag] <= 1'b0;
            end else if (state == WAIT && data_valid && cur_remain != '0) begin
                remain[cur_tag] <= cur_remain - WORDS_W'(1);
            end
            if (cpl_vld && cpl_ready) begin
                pending[cpl_tag] <= 1'b1;
                remain[cpl_tag]  <= cpl_words;
                err_tag[cpl_tag] <= cpl_err;
            end
        end
    end

endmodule
